// File: rtl/rol_seq_unit_pkg.sv
// rtl/rol_seq_unit_pkg.sv - shared constants, state encoding and rotate helper
package rol_seq_unit_pkg;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ROTATE = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
        return {v[WIDTH-2:0], v[WIDTH-1]};
    endfunction

endpackage

// File: rtl/rot_counter.sv
// rtl/rot_counter.sv - 3-bit loadable down-counter with zero/one flags
module rot_counter
    import rol_seq_unit_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [AMT_W-1:0] load_val,
    input  logic             en,
    output logic [AMT_W-1:0] count,
    output logic             is_zero,
    output logic             is_one
);

    logic [AMT_W-1:0] cnt_q;
    logic [AMT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count   = cnt_q;
    assign is_zero = (cnt_q == '0);
    assign is_one  = (cnt_q == AMT_W'(1));

endmodule

// File: rtl/rol_seq_unit.sv
// rtl/rol_seq_unit.sv - multi-cycle rotate-left unit, one bit position per clock
module rol_seq_unit
    import rol_seq_unit_pkg::*;
(
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [WIDTH-1:0] DATA,
    input  logic [7:0]       SHIFT,
    output logic [WIDTH-1:0] RESULT,
    output logic             VALID,
    output logic             BUSY
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] wr_q, wr_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;

    logic             cnt_load;
    logic             cnt_en;
    logic [AMT_W-1:0] cnt_val;
    logic             cnt_is_zero;
    logic             cnt_is_one;
    logic [AMT_W-1:0] amt;
    logic             unused_shift_hi;

    // Only the low bits matter: amounts are taken modulo the operand width.
    assign amt             = SHIFT[AMT_W-1:0];
    assign unused_shift_hi = |SHIFT[7:AMT_W] | (|cnt_val);

    rot_counter u_cnt (
        .clk      (CLK),
        .rst_n    (RESET),
        .load     (cnt_load),
        .load_val (amt),
        .en       (cnt_en),
        .count    (cnt_val),
        .is_zero  (cnt_is_zero),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        result_d = result_q;
        valid_d  = 1'b0;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    wr_d     = DATA;
                    cnt_load = 1'b1;
                    if (amt == '0) begin
                        state_d  = ST_DONE;
                        result_d = DATA;
                        valid_d  = 1'b1;
                    end else begin
                        state_d = ST_ROTATE;
                    end
                end
            end
            ST_ROTATE: begin
                wr_d   = rol1(wr_q);
                cnt_en = 1'b1;
                // The zero term only guards against a corrupted counter.
                if (cnt_is_one || cnt_is_zero) begin
                    state_d  = ST_DONE;
                    result_d = rol1(wr_q);
                    valid_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= ST_IDLE;
            wr_q     <= '0;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign RESULT = result_q;
    assign VALID  = valid_q;
    assign BUSY   = (state_q == ST_ROTATE) || (state_q == ST_DONE);

endmodule
